matvec_ctrl: RTL

Sequencer for the 8×8 matrix-vector MAC array: on `start` it fetches the A matrix rows and the B vector from an Avalon-MM style word memory. It unpacks each word byte-by-byte into the row FIFOs and the B FIFO, then drains all FIFOs in lock-step into the MAC array. It raises `done` once the results are settled. It sits between the memory wrapper and the FIFO/MAC datapath and owns every FIFO write/read enable and MAC control signal.

---
 rtl/matvec_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/matvec_ctrl.sv
// matvec_ctrl: fetches A rows and the B vector word by word, unpacks bytes into the row/B FIFOs,
// then drains all FIFOs in lock-step into the MAC array. MATVEC_CTRL_PERF_EN adds perf_cycles.
module matvec_ctrl #(
   parameter int unsigned DIM       = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clr,
   output logic                  busy,
   output logic                  done,
   output logic                  mac_clr,
   output logic                  mac_en,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_read,
   input  logic                  mem_waitrequest,
   input  logic [DIM*DATA_W-1:0] mem_readdata,
   input  logic                  mem_readdatavalid,
   output logic [DATA_W-1:0]     fifo_wdata,
   output logic [DIM-1:0]        fifo_a_wren,
   output logic                  fifo_b_wren,
   output logic                  fifo_rden
`ifdef MATVEC_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);

   localparam int unsigned RW = $clog2(DIM + 1);
   localparam int unsigned BW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int unsigned WW = DIM * DATA_W;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, COMPUTE, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       r_q, r_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic [WW-1:0]       shift_q, shift_d;
   logic                start_acc;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                mac_clr_q, mac_clr_d;
   logic                mac_en_q, mac_en_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_read_q, mem_read_d;
   logic [DATA_W-1:0]   fifo_wdata_q, fifo_wdata_d;
   logic [DIM-1:0]      fifo_a_wren_q, fifo_a_wren_d;
   logic                fifo_b_wren_q, fifo_b_wren_d;
   logic                fifo_rden_q, fifo_rden_d;

   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      start_acc = 1'b0;
      mac_clr_d = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = REQ;
               r_d       = '0;
               start_acc = 1'b1;
               mac_clr_d = 1'b1;
            end else if (clr) begin
               state_d   = IDLE;
               mac_clr_d = 1'b1;
            end
         end
         REQ: begin
            if (!mem_waitrequest) state_d = WAIT;
         end
         WAIT: begin
            if (mem_readdatavalid) begin
               shift_d = mem_readdata;
               bcnt_d  = '0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            shift_d = shift_q >> DATA_W;
            if (bcnt_q == BW'(DIM - 1)) begin
               bcnt_d = '0;
               if (r_q == RW'(DIM)) begin
                  state_d = COMPUTE;
               end else begin
                  r_d     = r_q + 1'b1;
                  state_d = REQ;
               end
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         COMPUTE: begin
            if (bcnt_q == BW'(DIM - 1)) begin
               bcnt_d  = '0;
               state_d = DRAIN;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (bcnt_q == BW'(1)) begin
               bcnt_d  = '0;
               state_d = DONE;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so every port comes straight off a flop.
      busy_d        = (state_d != IDLE) && (state_d != DONE);
      done_d        = (state_d == DONE);
      mem_read_d    = (state_d == REQ);
      mem_addr_d    = ADDR_W'(BASE_ADDR) + ADDR_W'(r_d);
      fifo_wdata_d  = shift_d[DATA_W-1:0];
      fifo_a_wren_d = '0;
      fifo_b_wren_d = 1'b0;
      if (state_d == UNPACK) begin
         if (r_d == RW'(DIM)) fifo_b_wren_d = 1'b1;
         else                 fifo_a_wren_d = DIM'(1) << r_d;
      end
      fifo_rden_d   = (state_d == COMPUTE);
      mac_en_d      = fifo_rden_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         r_q           <= '0;
         bcnt_q        <= '0;
         shift_q       <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mac_clr_q     <= 1'b0;
         mac_en_q      <= 1'b0;
         mem_addr_q    <= ADDR_W'(BASE_ADDR);
         mem_read_q    <= 1'b0;
         fifo_wdata_q  <= '0;
         fifo_a_wren_q <= '0;
         fifo_b_wren_q <= 1'b0;
         fifo_rden_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         r_q           <= r_d;
         bcnt_q        <= bcnt_d;
         shift_q       <= shift_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mac_clr_q     <= mac_clr_d;
         mac_en_q      <= mac_en_d;
         mem_addr_q    <= mem_addr_d;
         mem_read_q    <= mem_read_d;
         fifo_wdata_q  <= fifo_wdata_d;
         fifo_a_wren_q <= fifo_a_wren_d;
         fifo_b_wren_q <= fifo_b_wren_d;
         fifo_rden_q   <= fifo_rden_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mac_clr     = mac_clr_q;
   assign mac_en      = mac_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_read    = mem_read_q;
   assign fifo_wdata  = fifo_wdata_q;
   assign fifo_a_wren = fifo_a_wren_q;
   assign fifo_b_wren = fifo_b_wren_q;
   assign fifo_rden   = fifo_rden_q;

`ifdef MATVEC_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = start_acc ? '0 : perf_q + 32'(busy_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`endif

endmodule
